// File: rtl/y86_stage_sequencer_pkg.sv
// Shared Y86 definitions: field widths, icode and stat encodings, sequencer states, stage strobe bundle.
package y86_stage_sequencer_pkg;

    localparam int unsigned ADDR_WID = 4;

    localparam logic [ADDR_WID-1:0] IHALT   = 4'h0;
    localparam logic [ADDR_WID-1:0] INOP    = 4'h1;
    localparam logic [ADDR_WID-1:0] IRRMOVL = 4'h2;
    localparam logic [ADDR_WID-1:0] IIRMOVL = 4'h3;
    localparam logic [ADDR_WID-1:0] IRMMOVL = 4'h4;
    localparam logic [ADDR_WID-1:0] IMRMOVL = 4'h5;
    localparam logic [ADDR_WID-1:0] IOPL    = 4'h6;
    localparam logic [ADDR_WID-1:0] IJXX    = 4'h7;
    localparam logic [ADDR_WID-1:0] ICALL   = 4'h8;
    localparam logic [ADDR_WID-1:0] IRET    = 4'h9;
    localparam logic [ADDR_WID-1:0] IPUSHL  = 4'hA;
    localparam logic [ADDR_WID-1:0] IPOPL   = 4'hB;

    localparam logic [ADDR_WID-1:0] SAOK = 4'h1;
    localparam logic [ADDR_WID-1:0] SHLT = 4'h2;
    localparam logic [ADDR_WID-1:0] SADR = 4'h3;
    localparam logic [ADDR_WID-1:0] SINS = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
        logic w;
        logic pc;
    } strobe_t;

    // Stage strobes belonging to a state; the register write is gated by the instruction class.
    function automatic strobe_t state_strobes(input state_t s, input logic writes_reg);
        strobe_t st;
        st = '0;
        case (s)
            S_FETCH:     st.f  = 1'b1;
            S_DECODE:    st.d  = 1'b1;
            S_EXECUTE:   st.e  = 1'b1;
            S_MEMORY:    st.m  = 1'b1;
            S_WRITEBACK: st.w  = writes_reg;
            S_PCUPD:     st.pc = 1'b1;
            default:     st    = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/y86_stage_sequencer_icode_class.sv
// Combinational instruction classifier: memory access, register write-back, legal opcode.
module y86_stage_sequencer_icode_class
    import y86_stage_sequencer_pkg::*;
(
    input  logic [ADDR_WID-1:0] icode,
    output logic                is_mem_c,
    output logic                writes_reg_c,
    output logic                is_valid_c
);

    // Decode the class flags from the opcode.
    always_comb begin
        is_mem_c     = 1'b0;
        writes_reg_c = 1'b0;
        is_valid_c   = (icode <= IPOPL);
        case (icode)
            IRMMOVL:                             is_mem_c = 1'b1;
            IMRMOVL, ICALL, IRET, IPUSHL, IPOPL: begin
                is_mem_c     = 1'b1;
                writes_reg_c = 1'b1;
            end
            IRRMOVL, IIRMOVL, IOPL:              writes_reg_c = 1'b1;
            IHALT, INOP, IJXX:                   writes_reg_c = 1'b0;
            default: begin
                is_mem_c     = 1'b0;
                writes_reg_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle Y86 stage sequencer: one stage per state, per-stage strobes, status and counters.
module y86_stage_sequencer
    import y86_stage_sequencer_pkg::*;
#(
    parameter int unsigned CNT_WID = 32,
    parameter int unsigned MEM_TMO = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [ADDR_WID-1:0] icode,
    input  logic                imem_error,
    input  logic                dmem_error,
    input  logic                mem_ready,
    output logic                f_en,
    output logic                d_en,
    output logic                e_en,
    output logic                m_req,
    output logic                w_en,
    output logic                pc_en,
    output logic [ADDR_WID-1:0] stat,
    output logic [CNT_WID-1:0]  cycle_cnt,
    output logic [CNT_WID-1:0]  instr_cnt
);

    localparam int unsigned TMO_WID = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_WID-1:0] stat_nxt;
    logic [ADDR_WID-1:0] icode_q;
    logic [ADDR_WID-1:0] class_icode;
    logic [TMO_WID-1:0]  tmo_cnt;
    logic                is_mem_c;
    logic                writes_reg_c;
    logic                is_valid_c;
    strobe_t             stb_nxt;

    // The live fetch bus is classified during FETCH; afterwards the latched opcode is used.
    assign class_icode = (state == S_FETCH) ? icode : icode_q;

    y86_stage_sequencer_icode_class u_class (
        .icode        (class_icode),
        .is_mem_c     (is_mem_c),
        .writes_reg_c (writes_reg_c),
        .is_valid_c   (is_valid_c)
    );

    // Next-state and next-status decode.
    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    stat_nxt  = SADR;
                    state_nxt = S_HALT;
                end else if (!is_valid_c) begin
                    stat_nxt  = SINS;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE:  state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (icode_q == IHALT) begin
                    stat_nxt  = SHLT;
                    state_nxt = S_HALT;
                end else if (icode_q == INOP) begin
                    state_nxt = S_PCUPD;
                end else if (is_mem_c) begin
                    state_nxt = S_MEMORY;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (dmem_error) begin
                        stat_nxt  = SADR;
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end else if (tmo_cnt == TMO_WID'(MEM_TMO - 1)) begin
                    stat_nxt  = SADR;
                    state_nxt = S_HALT;
                end
            end
            S_WRITEBACK: state_nxt = S_PCUPD;
            S_PCUPD:     state_nxt = run ? S_FETCH : S_IDLE;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_IDLE;
        endcase
        stb_nxt = state_strobes(state_nxt, writes_reg_c);
    end

    // State, status, counters and strobes; strobes are registered from the next state so they track the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            stat      <= SAOK;
            icode_q   <= '0;
            tmo_cnt   <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            {f_en, d_en, e_en, m_req, w_en, pc_en} <= '0;
        end else begin
            state   <= state_nxt;
            stat    <= stat_nxt;
            if (state == S_FETCH) icode_q <= icode;
            tmo_cnt <= (state == S_MEMORY) ? tmo_cnt + TMO_WID'(1) : '0;
            if (state != S_IDLE && state != S_HALT) cycle_cnt <= cycle_cnt + CNT_WID'(1);
            if (state == S_PCUPD) instr_cnt <= instr_cnt + CNT_WID'(1);
            {f_en, d_en, e_en, m_req, w_en, pc_en} <= stb_nxt;
        end
    end

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed scoreboard bench for the Y86 stage sequencer.
module tb_y86_stage_sequencer;
    import y86_stage_sequencer_pkg::*;

    localparam int unsigned CNT_WID = 32;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] SF   = 6'b100000;
    localparam logic [5:0] SD   = 6'b010000;
    localparam logic [5:0] SE   = 6'b001000;
    localparam logic [5:0] SM   = 6'b000100;
    localparam logic [5:0] SW   = 6'b000010;
    localparam logic [5:0] SP   = 6'b000001;

    typedef struct packed {
        logic [5:0]          stb;
        logic [ADDR_WID-1:0] st;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                run;
    logic [ADDR_WID-1:0] icode;
    logic                imem_error;
    logic                dmem_error;
    logic                mem_ready;
    logic                f_en, d_en, e_en, m_req, w_en, pc_en;
    logic [ADDR_WID-1:0] stat;
    logic [CNT_WID-1:0]  cycle_cnt;
    logic [CNT_WID-1:0]  instr_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    y86_stage_sequencer #(.CNT_WID(CNT_WID), .MEM_TMO(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .icode      (icode),
        .imem_error (imem_error),
        .dmem_error (dmem_error),
        .mem_ready  (mem_ready),
        .f_en       (f_en),
        .d_en       (d_en),
        .e_en       (e_en),
        .m_req      (m_req),
        .w_en       (w_en),
        .pc_en      (pc_en),
        .stat       (stat),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [5:0] s, input logic [ADDR_WID-1:0] st);
        exp_t e;
        e.stb = s;
        e.st  = st;
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t       e;
        logic [5:0] obs;
        @(posedge clk);
        #1;
        obs = {f_en, d_en, e_en, m_req, w_en, pc_en};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed strobes=%b", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.stb) else begin
                errors++;
                $error("FAIL %s strobes observed=%b expected=%b", tag, obs, e.stb);
            end
            checks++;
            assert (stat === e.st) else begin
                errors++;
                $error("FAIL %s stat observed=%0d expected=%0d", tag, stat, e.st);
            end
        end
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_WID-1:0] c, input logic [CNT_WID-1:0] n);
        checks++;
        assert (cycle_cnt === c) else begin
            errors++;
            $error("FAIL %s cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, c);
        end
        checks++;
        assert (instr_cnt === n) else begin
            errors++;
            $error("FAIL %s instr_cnt observed=%0d expected=%0d", tag, instr_cnt, n);
        end
    endtask

    task automatic do_reset(input string tag);
        run        = 1'b0;
        mem_ready  = 1'b0;
        dmem_error = 1'b0;
        imem_error = 1'b0;
        rst        = 1'b1;
        push(NONE, SAOK);
        tick(tag);
        chk_cnt(tag, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        icode = IHALT;
        do_reset("reset");

        // OPl: five stages, write-back enabled; run dropped after FETCH still completes.
        icode = IOPL; run = 1'b1;
        push(SF, SAOK); tick("opl_f");
        run = 1'b0;
        push(SD, SAOK); push(SE, SAOK); push(SW, SAOK); push(SP, SAOK); push(NONE, SAOK);
        ticks("opl", 5);
        chk_cnt("opl_cnt", 5, 1);

        // mrmovl with mem_ready on the third memory cycle.
        do_reset("reset2");
        icode = IMRMOVL; run = 1'b1;
        push(SF, SAOK); tick("mr_f");
        run = 1'b0;
        push(SD, SAOK); push(SE, SAOK); push(SM, SAOK); push(SM, SAOK); push(SM, SAOK);
        ticks("mr", 5);
        mem_ready = 1'b1;
        push(SW, SAOK); tick("mr_w");
        mem_ready = 1'b0;
        push(SP, SAOK); push(NONE, SAOK);
        ticks("mr_end", 2);
        chk_cnt("mr_cnt", 8, 1);

        // rmmovl with immediate mem_ready: write-back state with no register write.
        do_reset("reset3");
        icode = IRMMOVL; run = 1'b1; mem_ready = 1'b1;
        push(SF, SAOK); tick("rm_f");
        run = 1'b0;
        push(SD, SAOK); push(SE, SAOK); push(SM, SAOK); push(NONE, SAOK); push(SP, SAOK); push(NONE, SAOK);
        ticks("rm", 6);
        mem_ready = 1'b0;
        chk_cnt("rm_cnt", 6, 1);

        // halt: status HLT after EXECUTE, then everything but reset is ignored.
        do_reset("reset4");
        icode = IHALT; run = 1'b1;
        push(SF, SAOK); push(SD, SAOK); push(SE, SAOK); push(NONE, SHLT);
        ticks("hlt", 4);
        icode = IOPL; mem_ready = 1'b1;
        push(NONE, SHLT); push(NONE, SHLT); push(NONE, SHLT);
        ticks("hlt_hold", 3);
        chk_cnt("hlt_cnt", 3, 0);
        do_reset("hlt_rst");
        push(NONE, SAOK); tick("hlt_idle");

        // Illegal opcode at fetch.
        icode = 4'hC; run = 1'b1;
        push(SF, SAOK); push(NONE, SINS);
        ticks("ins", 2);
        chk_cnt("ins_cnt", 1, 0);

        // Instruction fetch address error.
        do_reset("reset5");
        icode = IOPL; imem_error = 1'b1; run = 1'b1;
        push(SF, SAOK); push(NONE, SADR);
        ticks("imem", 2);

        // Memory timeout: fifteen request cycles then ADR.
        do_reset("reset6");
        icode = IMRMOVL; run = 1'b1;
        push(SF, SAOK); push(SD, SAOK); push(SE, SAOK);
        for (int i = 0; i < 15; i++) push(SM, SAOK);
        push(NONE, SADR); push(NONE, SADR);
        ticks("tmo", 20);
        chk_cnt("tmo_cnt", 18, 0);

        // Data memory error reported with mem_ready.
        do_reset("reset7");
        icode = ICALL; run = 1'b1; mem_ready = 1'b1; dmem_error = 1'b1;
        push(SF, SAOK); push(SD, SAOK); push(SE, SAOK); push(SM, SAOK); push(NONE, SADR);
        ticks("dmem", 5);
        chk_cnt("dmem_cnt", 4, 0);

        // Back-to-back nops with run held, run dropped during EXECUTE of the second.
        do_reset("reset8");
        icode = INOP; run = 1'b1;
        push(SF, SAOK); push(SD, SAOK); push(SE, SAOK); push(SP, SAOK); push(SF, SAOK); push(SD, SAOK); push(SE, SAOK);
        ticks("nop", 7);
        run = 1'b0;
        push(SP, SAOK); push(NONE, SAOK);
        ticks("nop_end", 2);
        chk_cnt("nop_cnt", 8, 2);

        // rrmovl with run dropped during EXECUTE.
        do_reset("reset9");
        icode = IRRMOVL; run = 1'b1;
        push(SF, SAOK); push(SD, SAOK); push(SE, SAOK);
        ticks("rr", 3);
        run = 1'b0;
        push(SW, SAOK); push(SP, SAOK); push(NONE, SAOK); push(NONE, SAOK);
        ticks("rr_end", 4);
        chk_cnt("rr_cnt", 5, 1);

        // Reset during MEMORY drops m_req; a late mem_ready is ignored in IDLE.
        do_reset("reset10");
        icode = IPOPL; run = 1'b1;
        push(SF, SAOK); push(SD, SAOK); push(SE, SAOK); push(SM, SAOK);
        ticks("rstm", 4);
        do_reset("rstm_rst");
        mem_ready = 1'b1;
        push(NONE, SAOK); push(NONE, SAOK);
        ticks("rstm_idle", 2);
        chk_cnt("rstm_cnt", 0, 0);
        mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
